// File: rtl/player_vertical_motion.sv
// player_vertical_motion: tick-paced vertical fall, platform landing and death detection
module player_vertical_motion #(
  parameter int TICK_DIV = 1666667,
  parameter int START_H  = 120,
  parameter int MAX_VEL  = 8,
  parameter int DEATH_LO = 60,
  parameter int DEATH_HI = 360
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dir,
  input  logic [2:0] lines,
  output logic [8:0] height,
  output logic       is_dead,
  output logic       grounded,
  output logic       landed
);
  typedef enum logic [1:0] {GROUNDED, FALLING, DEAD} state_t;
  localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic signed [10:0] D_LO = 11'(DEATH_LO);
  localparam logic signed [10:0] D_HI = 11'(DEATH_HI);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [8:0] height_q, height_d, surf;
  logic [7:0] vel_q, vel_d;
  logic is_dead_q, is_dead_d, grounded_q, grounded_d, landed_q, landed_d;
  logic tick, supported, land, lo0, lo1, up0, up1;
  logic signed [10:0] h, v, cand;
  // motion tick divider and candidate height / landing evaluation
  always_comb begin
    tick = cnt_q == CW'(TICK_DIV - 1);
    cnt_d = tick ? '0 : cnt_q + CW'(1);
    supported = dir ? ((height_q == 9'd180 && lines[1]) || (height_q == 9'd300 && lines[2]))
                    : ((height_q == 9'd120 && lines[0]) || (height_q == 9'd240 && lines[1]));
    h = $signed({2'b00, height_q});
    v = $signed({3'b000, vel_q});
    cand = dir ? h + v : h - v;
    lo0 = lines[1] && h >= 11'sd240 && cand <= 11'sd240;
    lo1 = lines[0] && h >= 11'sd120 && cand <= 11'sd120;
    up0 = lines[1] && h <= 11'sd180 && cand >= 11'sd180;
    up1 = lines[2] && h <= 11'sd300 && cand >= 11'sd300;
    land = dir ? (up0 || up1) : (lo0 || lo1);
    surf = dir ? (up0 ? 9'd180 : 9'd300) : (lo0 ? 9'd240 : 9'd120);
  end
  // next-state: all motion happens only on tick clocks; DEAD freezes everything
  always_comb begin
    state_d = state_q;
    height_d = height_q;
    vel_d = vel_q;
    is_dead_d = is_dead_q;
    grounded_d = grounded_q;
    landed_d = 1'b0;
    if (tick) begin
      case (state_q)
        GROUNDED: begin
          vel_d = supported ? 8'd0 : 8'd2;
          if (!supported) begin
            height_d = dir ? height_q + 9'd1 : height_q - 9'd1;
            state_d = FALLING;
            grounded_d = 1'b0;
          end
        end
        FALLING: begin
          if (land) begin
            height_d = surf;
            vel_d = 8'd0;
            state_d = GROUNDED;
            grounded_d = 1'b1;
            landed_d = 1'b1;
          end else if (cand < D_LO || cand > D_HI) begin
            state_d = DEAD;
            is_dead_d = 1'b1;
          end else begin
            height_d = cand[8:0];
            vel_d = vel_q >= 8'(MAX_VEL) ? 8'(MAX_VEL) : vel_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end
  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= GROUNDED;
      cnt_q <= '0;
      height_q <= 9'(START_H);
      vel_q <= 8'd0;
      is_dead_q <= 1'b0;
      grounded_q <= 1'b1;
      landed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      height_q <= height_d;
      vel_q <= vel_d;
      is_dead_q <= is_dead_d;
      grounded_q <= grounded_d;
      landed_q <= landed_d;
    end
  end
  assign height = height_q;
  assign is_dead = is_dead_q;
  assign grounded = grounded_q;
  assign landed = landed_q;
endmodule

// File: tb/tb_player_vertical_motion.sv
// tb_player_vertical_motion: scoreboard bench with a behavioural motion model
module tb_player_vertical_motion;
  localparam int TD = 4;
  logic clk = 0, reset = 0, dir = 0;
  logic [2:0] lines = 3'b001;
  logic [8:0] height;
  logic is_dead, grounded, landed;
  int checks = 0, failures = 0;
  logic [11:0] exp_q[$];
  int m_h = 120, m_v = 0, m_cnt = 0;
  bit m_dead = 0, m_gnd = 1, m_lnd = 0;
  int surf[2][2] = '{'{240, 120}, '{180, 300}};
  int lbit[2][2] = '{'{1, 0}, '{1, 2}};

  player_vertical_motion #(.TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .dir(dir), .lines(lines),
    .height(height), .is_dead(is_dead), .grounded(grounded), .landed(landed)
  );

  always #5 clk = ~clk;

  function automatic void model_step(bit r, bit d, bit [2:0] l);
    int di, cand, hit, s;
    bit sup;
    di = d;
    if (!r) begin
      m_h = 120; m_v = 0; m_cnt = 0; m_dead = 0; m_gnd = 1; m_lnd = 0;
      return;
    end
    m_lnd = 0;
    if (m_cnt != TD - 1) begin
      m_cnt++;
      return;
    end
    m_cnt = 0;
    if (m_dead) return;
    if (m_gnd) begin
      sup = 0;
      for (int k = 0; k < 2; k++) if (m_h == surf[di][k] && l[lbit[di][k]]) sup = 1;
      if (!sup) begin
        m_h += d ? 1 : -1;
        m_v = 2;
        m_gnd = 0;
      end
    end else begin
      cand = d ? m_h + m_v : m_h - m_v;
      hit = -1;
      for (int k = 0; k < 2; k++) begin
        s = surf[di][k];
        if (hit < 0 && l[lbit[di][k]] && (d ? (m_h <= s && cand >= s) : (m_h >= s && cand <= s))) hit = s;
      end
      if (hit >= 0) begin
        m_h = hit; m_v = 0; m_gnd = 1; m_lnd = 1;
      end else if (cand < 60 || cand > 360) begin
        m_dead = 1;
      end else begin
        m_h = cand;
        m_v = m_v + 1 > 8 ? 8 : m_v + 1;
      end
    end
  endfunction

  task automatic cyc(input bit r, input bit d, input bit [2:0] l);
    @(negedge clk);
    reset = r;
    dir = d;
    lines = l;
    model_step(r, d, l);
    exp_q.push_back({9'(m_h), m_dead, m_gnd, m_lnd});
  endtask

  task automatic ticks(input int n, input bit d, input bit [2:0] l);
    repeat (n * TD) cyc(1, d, l);
  endtask

  task automatic settle;
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, want);
    end
  endtask

  initial begin : monitor
    logic [11:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({height, is_dead, grounded, landed} !== e) begin
          failures++;
          $display("FAIL cycle_out t=%0t got h=%0d dead=%b gnd=%b lnd=%b expected h=%0d dead=%b gnd=%b lnd=%b",
                   $time, height, is_dead, grounded, landed, e[11:3], e[2], e[1], e[0]);
        end
      end
    end
  end

  initial begin : driver
    bit rd;
    bit [2:0] rl;
    cyc(0, 0, 3'b001);
    cyc(0, 0, 3'b001);
    settle;
    chk("reset_h", height, 120);
    chk("reset_gnd", grounded, 1);
    chk("reset_dead", is_dead, 0);
    ticks(10, 0, 3'b001);
    settle;
    chk("rest_h", height, 120);
    chk("rest_gnd", grounded, 1);
    ticks(11, 1, 3'b011);
    settle;
    chk("up_land_h", height, 180);
    chk("up_land_gnd", grounded, 1);
    ticks(2, 1, 3'b011);
    settle;
    chk("up_hold_h", height, 180);
    cyc(0, 0, 3'b011);
    ticks(20, 1, 3'b000);
    settle;
    chk("rise_h", height, 252);
    ticks(3, 0, 3'b011);
    settle;
    chk("land240_h", height, 240);
    ticks(19, 0, 3'b001);
    settle;
    chk("clamp120_h", height, 120);
    chk("clamp120_gnd", grounded, 1);
    ticks(13, 0, 3'b000);
    settle;
    chk("dead_flag", is_dead, 1);
    chk("dead_h", height, 60);
    ticks(1, 1, 3'b111);
    ticks(1, 0, 3'b010);
    settle;
    chk("dead_frozen_h", height, 60);
    chk("dead_frozen_flag", is_dead, 1);
    cyc(0, 0, 3'b000);
    settle;
    chk("revive_h", height, 120);
    chk("revive_dead", is_dead, 0);
    ticks(20, 1, 3'b000);
    ticks(3, 0, 3'b011);
    ticks(8, 0, 3'b001);
    settle;
    chk("midfall_h", height, 204);
    repeat (2) cyc(1, 0, 3'b001);
    cyc(0, 0, 3'b000);
    settle;
    chk("abort_h", height, 120);
    chk("abort_gnd", grounded, 1);
    repeat (3) cyc(1, 0, 3'b000);
    settle;
    chk("pre_tick_h", height, 120);
    cyc(1, 0, 3'b000);
    settle;
    chk("first_tick_h", height, 119);
    cyc(0, 0, 3'b001);
    ticks(1, 1, 3'b100);
    settle;
    chk("flip_h", height, 121);
    ticks(27, 1, 3'b100);
    settle;
    chk("land300_h", height, 300);
    chk("land300_gnd", grounded, 1);
    rd = 0;
    rl = 3'b001;
    repeat (4000) begin
      if ($urandom_range(0, 15) == 0) begin
        rd = 1'($urandom);
        rl = 3'($urandom);
      end
      cyc($urandom_range(0, 299) != 0, rd, rl);
    end
    repeat (3) @(negedge clk);
    chk("drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
